// File: rtl/hex_display_scheduler_pkg.sv
// Shared types and constants for the hex display scheduler and its tick generator.
package hex_display_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int unsigned DEF_TICK_DIV    = 25_000_000;
  localparam int unsigned DEF_DWELL_TICKS = 4;

  // Index/counter width for n values; never narrower than one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex_display_scheduler_tick.sv
// tick_gen: free-running prescaler, one-cycle tick every DIV clock cycles.
module tick_gen
  import hex_display_scheduler_pkg::*;
#(
  parameter int unsigned DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CNT_W = sel_w(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  // Count 0..DIV-1 and wrap; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler: round-robin time-sharing of NUM_SRC value sources onto
// the seven-segment display path, with manual advance and hold.
// Optional build macro KEY_SYNC_EN: adv_req becomes an async active-low KEY that
// is synchronized and falling-edge detected (one press = one advance).
module hex_display_scheduler
  import hex_display_scheduler_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
  parameter int unsigned DWELL_TICKS = DEF_DWELL_TICKS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  input  logic                        adv_req,
  input  logic                        hold_req,
  output logic [DATA_W-1:0]           disp_value,
  output logic [$clog2(NUM_SRC)-1:0]  disp_sel,
  output logic                        disp_valid,
  output logic                        switch_pulse
);

  localparam int unsigned SEL_W   = sel_w(NUM_SRC);
  localparam int unsigned DWELL_W = sel_w(DWELL_TICKS);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_TICKS - 1);

  state_e               state, state_nxt;
  logic [DWELL_W-1:0]   dwell, dwell_nxt;
  logic [SEL_W-1:0]     sel_nxt;
  logic [DATA_W-1:0]    value_nxt;
  logic                 valid_nxt;
  logic                 pulse_nxt;
  logic                 tick;
  logic                 adv_c;
  logic                 any_valid_c;
  logic [SEL_W-1:0]     next_sel_c;
  logic [SEL_W-1:0]     first_sel_c;
  logic [DATA_W-1:0]    src_arr [NUM_SRC];

  // First valid index after cur, wrapping; returns cur if it is the only valid one.
  function automatic logic [SEL_W-1:0] next_valid(input logic [NUM_SRC-1:0] valid,
                                                  input logic [SEL_W-1:0]   cur);
    logic [SEL_W-1:0] res;
    logic             found;
    int unsigned      idx;
    res   = cur;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = (32'(cur) + k) % NUM_SRC;
      if (!found && valid[SEL_W'(idx)]) begin
        res   = SEL_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Lowest valid index, used when leaving IDLE.
  function automatic logic [SEL_W-1:0] lowest_valid(input logic [NUM_SRC-1:0] valid);
    logic [SEL_W-1:0] res;
    res = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (valid[SEL_W'(i)]) begin
        res = SEL_W'(i);
      end
    end
    return res;
  endfunction

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_slice
    assign src_arr[g] = src_data[g*DATA_W +: DATA_W];
  end

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

`ifdef KEY_SYNC_EN
  logic key_meta, key_sync, key_prev;

  // Two-flop synchronizer plus history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
      key_prev <= 1'b1;
    end else begin
      key_meta <= adv_req;
      key_sync <= key_meta;
      key_prev <= key_sync;
    end
  end

  assign adv_c = key_prev & ~key_sync;
`else
  assign adv_c = adv_req;
`endif

  assign any_valid_c = |src_valid;
  assign next_sel_c  = next_valid(src_valid, disp_sel);
  assign first_sel_c = lowest_valid(src_valid);

  // State and display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dwell        <= '0;
      disp_sel     <= '0;
      disp_value   <= '0;
      disp_valid   <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      state        <= state_nxt;
      dwell        <= dwell_nxt;
      disp_sel     <= sel_nxt;
      disp_value   <= value_nxt;
      disp_valid   <= valid_nxt;
      switch_pulse <= pulse_nxt;
    end
  end

  // Next-state: invalidation beats adv_req, which beats dwell expiry.
  always_comb begin
    state_nxt = state;
    dwell_nxt = dwell;
    sel_nxt   = disp_sel;
    unique case (state)
      IDLE: begin
        if (any_valid_c) begin
          state_nxt = SHOW;
          sel_nxt   = first_sel_c;
          dwell_nxt = '0;
        end
      end
      SHOW, HOLD: begin
        if (!src_valid[disp_sel]) begin
          dwell_nxt = '0;
          if (any_valid_c) begin
            sel_nxt = next_sel_c;
          end else begin
            state_nxt = IDLE;
          end
        end else if (adv_c) begin
          sel_nxt   = next_sel_c;
          dwell_nxt = '0;
        end else if (state == SHOW && tick) begin
          if (dwell == DWELL_LAST) begin
            sel_nxt   = next_sel_c;
            dwell_nxt = '0;
          end else begin
            dwell_nxt = dwell + DWELL_W'(1);
          end
        end
        if (state_nxt != IDLE) begin
          state_nxt = hold_req ? HOLD : SHOW;
        end
      end
      default: begin
        state_nxt = IDLE;
        dwell_nxt = '0;
      end
    endcase
    valid_nxt = (state_nxt != IDLE);
    value_nxt = valid_nxt ? src_arr[sel_nxt] : '0;
    pulse_nxt = valid_nxt && ((sel_nxt != disp_sel) || (state == IDLE));
  end

endmodule

// File: doc/hex_display_scheduler.md
Name: hex_display_scheduler

Overview:
Time-shares the board's seven-segment display path between up to NUM_SRC 16-bit value sources, such as counters and status words.
- Rotates round-robin through the valid sources, showing each for a fixed number of prescaled ticks.
- Supports manual advance and a pin/hold mode.
- Its outputs feed the existing per-digit sseg decoders, via disp_value nibbles, plus a source-index digit.

Parameters:
NUM_SRC, 4, number of sources (2..8)
DATA_W, 16, width of each source value
TICK_DIV, 25_000_000, clk cycles per tick (0.5 s at 50 MHz)
DWELL_TICKS, 4, ticks each source is shown before auto-advance (>=1)

Ports:
clk  in  1  system clock (CLOCK_50)
rst_n  in  1  asynchronous active-low reset (KEY-driven)
src_valid  in  NUM_SRC  per-source valid/enable level
src_data  in  NUM_SRC*DATA_W  packed source values; source i = bits [i*DATA_W +: DATA_W]
adv_req  in  1  advance to next valid source
hold_req  in  1  level; high = pin current source (no auto-advance)
disp_value  out  DATA_W  registered value of the selected source
disp_sel  out  $clog2(NUM_SRC)  selected source index
disp_valid  out  1  a source is being displayed
switch_pulse  out  1  one-cycle strobe when disp_sel changes or display becomes valid

Behaviour:
Reset:
- Asynchronous assert, synchronous release.
- State=IDLE; prescaler=0; dwell=0; disp_sel=0; disp_value=0; disp_valid=0; switch_pulse=0.

Prescaler:
- Counts 0..TICK_DIV-1, then wraps to 0.
- tick=1 for exactly one cycle when count==TICK_DIV-1, giving a tick period of TICK_DIV cycles.
- Free-running in all states; never reset except by rst_n.

"Next valid" = first i with src_valid[i], searching disp_sel+1, disp_sel+2, ... and wrapping modulo NUM_SRC. It may return disp_sel itself if that is the only valid source.

States:
- IDLE:
  - disp_valid=0, disp_value=0.
  - If any src_valid: go to SHOW with disp_sel=lowest valid index, dwell=0, switch_pulse next cycle.
- SHOW:
  - On tick, dwell++.
  - On tick with dwell==DWELL_TICKS-1: disp_sel=next valid, dwell=0.
  - hold_req=1: go to HOLD, keeping dwell.
- HOLD:
  - dwell frozen; no auto-advance.
  - hold_req=0: return to SHOW, resuming the frozen dwell.

Advance and invalidation rules:
- adv_req (SHOW or HOLD): disp_sel=next valid, dwell=0, state unchanged.
- Current source invalid (src_valid[disp_sel]=0) in SHOW/HOLD:
  - If another source is valid: advance to it, dwell=0.
  - If none are valid: go to IDLE.

Priority, highest first: invalidation > adv_req > dwell expiry.
- adv_req coincident with expiry gives a single advance.
- adv_req plus hold_req: advance, then enter or stay in HOLD.

switch_pulse:
- Asserted the cycle after disp_sel changes value, and on IDLE->SHOW.
- An advance that returns the same index does not pulse.

disp_value:
- Registered copy of the selected source slice while disp_valid; 1-cycle latency from src_data.
- Updates live each cycle, not only on switch.
- disp_value and disp_sel update in the same cycle.

Optional Feature:
Macro: KEY_SYNC_EN
- Defined: adv_req is treated as an asynchronous, active-low pushbutton (KEY).
  - Passes through a 2-flop synchronizer, then a falling-edge detector.
  - One press = one advance; latency 3 cycles from pin to disp_sel change.
  - Synchronizer flops reset to 1.
- Undefined: adv_req is a synchronous active-high signal; every high cycle advances once; latency 1 cycle.

Decomposition:
Shared package:
- State enum (IDLE, SHOW, HOLD).
- Default constants for TICK_DIV and DWELL_TICKS.
- A SEL_W = $clog2(NUM_SRC) helper.

Sub-module tick_gen:
- Parameter DIV; ports clk, rst_n, tick.
- Reusable by the existing counter designs.

The round-robin next-valid search stays a combinational function inside the top.

Test Plan:
Common parameters: TICK_DIV=4, DWELL_TICKS=2, NUM_SRC=4, src i data = 16'h1111*(i+1).
1. Reset: assert rst_n=0 mid-SHOW -> all outputs 0 immediately; after release with src_valid=0, disp_valid stays 0.
2. Rotation: src_valid=4'b1011 -> disp_sel sequence 0,1,3,0, each held 8 cycles; disp_value 1111,2222,4444,1111; switch_pulse once per change.
3. Manual advance: adv_req 1 cycle while on src 1 (valid=4'b1111) -> disp_sel=2 next cycle; dwell restarts (src 2 shown full 8 cycles).
4. Hold: hold_req=1 on src 2 for 40 cycles -> disp_sel stays 2; src_data[2] changed to 16'hBEEF -> disp_value=BEEF one cycle later; release resumes with remaining dwell.
5. Invalidation: drop src_valid[disp_sel] -> advance next cycle; then src_valid=0 -> IDLE, disp_valid=0, disp_value=0.
6. Collision: adv_req on the dwell-expiry tick with valid=4'b1111 on src 0 -> disp_sel=1, not 2; single switch_pulse.
